// File: rtl/pulse_emitter_pkg.sv
// pulse_emitter_pkg: shared state encoding and gap counter sizing for pulse_emitter
package pulse_emitter_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;
    // Gap counter needs to hold GAP-1, never narrower than one bit.
    function automatic int gap_w(input int g);
        return ($clog2(g + 1) > 1) ? $clog2(g + 1) : 1;
    endfunction
endpackage

// File: rtl/pulse_emitter.sv
// pulse_emitter: emits load_value single-cycle inc pulses after a valid/ready load
// Ports:
//   aclk, arstn           clock and asynchronous active-low reset
//   clr                   synchronous abort, returns to idle without done
//   load_valid/load_ready load handshake, ready only while idle
//   load_value            number of pulses to emit
//   inc                   one-cycle pulse per count
//   remaining             pulses still to emit
//   busy                  high while pulsing or gapping
//   done                  one-cycle pulse on normal burst completion
module pulse_emitter
    import pulse_emitter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    output logic             inc,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done
);
    localparam int GW = gap_w(GAP);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           st, nxt;
    logic [WIDTH-1:0] rem_n;
    logic [GW-1:0]    g, g_n;
    logic             done_n;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            st         <= S_IDLE;
            remaining  <= '0;
            g          <= '0;
            inc        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            st         <= nxt;
            remaining  <= rem_n;
            g          <= g_n;
            inc        <= nxt == S_PULSE;
            busy       <= nxt == S_PULSE || nxt == S_GAP;
            done       <= done_n;
            load_ready <= nxt == S_IDLE;
        end
    end

    always_comb begin
        nxt    = st;
        rem_n  = remaining;
        g_n    = g;
        done_n = 1'b0;
        if (clr) begin
            nxt   = S_IDLE;
            rem_n = '0;
            g_n   = '0;
        end else begin
            case (st)
                S_IDLE:
                    if (load_valid) begin
                        // A zero-length burst completes at once but stays ready.
                        if (load_value == '0) done_n = 1'b1;
                        else begin
                            rem_n = load_value;
                            nxt   = S_PULSE;
                        end
                    end
                S_PULSE: begin
                    rem_n = remaining - WIDTH'(1);
                    if (remaining == WIDTH'(1)) nxt = S_DONE;
                    else if (GAP > 0) begin
                        nxt = S_GAP;
                        g_n = GAP_LOAD;
                    end
                end
                S_GAP:
                    if (g == '0) nxt = S_PULSE;
                    else g_n = g - GW'(1);
                S_DONE: nxt = S_IDLE;
            endcase
            done_n = done_n | (nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_pulse_emitter.sv
// tb_pulse_emitter: directed checks of pulse_emitter (GAP=0 and GAP=2) with Adder scoreboards
module tb_pulse_emitter;
    logic       aclk = 1'b0;
    logic       arstn = 1'b1;
    logic       clr = 1'b0;
    logic       lv0 = 1'b0, lv2 = 1'b0;
    logic [7:0] lval0 = '0, lval2 = '0;
    logic       rdy0, inc0, busy0, done0, rdy2, inc2, busy2, done2;
    logic [7:0] rem0, rem2, a0, a2;
    int         total = 0;
    int         bad = 0;
    int         miss;

    always #5 aclk = ~aclk;

    pulse_emitter #(.WIDTH(8), .GAP(0)) d0 (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load_valid(lv0), .load_ready(rdy0),
        .load_value(lval0), .inc(inc0), .remaining(rem0), .busy(busy0), .done(done0)
    );
    pulse_emitter #(.WIDTH(8), .GAP(2)) d2 (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load_valid(lv2), .load_ready(rdy2),
        .load_value(lval2), .inc(inc2), .remaining(rem2), .busy(busy2), .done(done2)
    );

    // Adder scoreboards: count inc pulses, cleared by clr or reset.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            a0 <= '0;
            a2 <= '0;
        end else if (clr) begin
            a0 <= '0;
            a2 <= '0;
        end else begin
            a0 <= a0 + {7'd0, inc0};
            a2 <= a2 + {7'd0, inc2};
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1 arstn = 1'b0;
        #3;
        chk("rst_ready", 32'(rdy0), 1);
        chk("rst_inc", 32'(inc0), 0);
        chk("rst_rem", 32'(rem0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        step();
        step();
        arstn = 1'b1;
        step();

        // GAP=0, load 5
        lv0 = 1'b1;
        lval0 = 8'd5;
        step();
        lv0 = 1'b0;
        chk("g0_ready_low", 32'(rdy0), 0);
        chk("g0_busy", 32'(busy0), 1);
        for (int i = 5; i >= 1; i--) begin
            chk("g0_inc", 32'(inc0), 1);
            chk("g0_rem", 32'(rem0), 32'(i));
            step();
        end
        chk("g0_inc_end", 32'(inc0), 0);
        chk("g0_done", 32'(done0), 1);
        chk("g0_rem_end", 32'(rem0), 0);
        chk("g0_busy_end", 32'(busy0), 0);
        chk("g0_ready_done", 32'(rdy0), 0);
        chk("g0_adder", 32'(a0), 5);
        step();
        chk("g0_done_once", 32'(done0), 0);
        chk("g0_ready_back", 32'(rdy0), 1);

        // GAP=2, load 3: pulses at k+1,k+4,k+7, done at k+8
        lv2 = 1'b1;
        lval2 = 8'd3;
        step();
        lv2 = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            chk($sformatf("g2_inc_c%0d", j), 32'(inc2), 32'((j % 3 == 1) && j <= 7));
            chk($sformatf("g2_done_c%0d", j), 32'(done2), 32'(j == 8));
            chk($sformatf("g2_ready_c%0d", j), 32'(rdy2), 0);
            step();
        end
        chk("g2_ready_back", 32'(rdy2), 1);
        chk("g2_adder", 32'(a2), 3);

        // clear the adders before the wrap test
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_adder0", 32'(a0), 0);
        chk("clr_adder2", 32'(a2), 0);

        // load 0: no pulses, done next cycle, ready stays high
        lv0 = 1'b1;
        lval0 = 8'd0;
        step();
        lv0 = 1'b0;
        chk("z_inc", 32'(inc0), 0);
        chk("z_done", 32'(done0), 1);
        chk("z_ready", 32'(rdy0), 1);
        chk("z_rem", 32'(rem0), 0);
        step();
        chk("z_done_once", 32'(done0), 0);
        chk("z_adder", 32'(a0), 0);

        // load 255 with a pending load of 7 held throughout the burst
        lv0 = 1'b1;
        lval0 = 8'd255;
        step();
        lval0 = 8'd7;
        miss = 0;
        for (int j = 1; j <= 255; j++) begin
            if (inc0 !== 1'b1 || rdy0 !== 1'b0 || rem0 !== 8'(256 - j)) miss++;
            step();
        end
        chk("max_pulse_misses", 32'(miss), 0);
        chk("max_inc_end", 32'(inc0), 0);
        chk("max_done", 32'(done0), 1);
        chk("max_adder", 32'(a0), 255);
        step();
        chk("max_ready_back", 32'(rdy0), 1);
        chk("max_no_queue", 32'(inc0), 0);
        step();
        lv0 = 1'b0;
        chk("seven_inc", 32'(inc0), 1);
        chk("seven_rem", 32'(rem0), 7);
        for (int j = 1; j <= 7; j++) step();
        chk("seven_done", 32'(done0), 1);
        chk("wrap_adder", 32'(a0), 6);
        step();

        // clr after the 3rd pulse of a 10-pulse burst
        lv0 = 1'b1;
        lval0 = 8'd10;
        step();
        lv0 = 1'b0;
        step();
        step();
        chk("clr_third_inc", 32'(inc0), 1);
        chk("clr_third_rem", 32'(rem0), 8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_inc", 32'(inc0), 0);
        chk("clr_rem", 32'(rem0), 0);
        chk("clr_done", 32'(done0), 0);
        chk("clr_ready", 32'(rdy0), 1);
        chk("clr_busy", 32'(busy0), 0);
        chk("clr_adder", 32'(a0), 0);
        step();
        chk("clr_no_done", 32'(done0), 0);
        chk("clr_no_inc", 32'(inc0), 0);

        // async reset mid-burst
        lv0 = 1'b1;
        lval0 = 8'd4;
        lv2 = 1'b1;
        lval2 = 8'd3;
        step();
        lv0 = 1'b0;
        lv2 = 1'b0;
        step();
        chk("ar_pre_inc", 32'(inc0), 1);
        chk("ar_pre_busy2", 32'(busy2), 1);
        #2 arstn = 1'b0;
        #1;
        chk("ar_inc", 32'(inc0), 0);
        chk("ar_rem", 32'(rem0), 0);
        chk("ar_busy", 32'(busy0), 0);
        chk("ar_ready", 32'(rdy0), 1);
        chk("ar_busy2", 32'(busy2), 0);
        chk("ar_rem2", 32'(rem2), 0);
        chk("ar_adder", 32'(a0), 0);
        step();
        arstn = 1'b1;
        step();
        chk("ar_idle_inc", 32'(inc0), 0);
        lv0 = 1'b1;
        lval0 = 8'd2;
        step();
        lv0 = 1'b0;
        chk("ar2_inc1", 32'(inc0), 1);
        chk("ar2_rem1", 32'(rem0), 2);
        step();
        chk("ar2_inc2", 32'(inc0), 1);
        chk("ar2_rem2", 32'(rem0), 1);
        step();
        chk("ar2_inc_end", 32'(inc0), 0);
        chk("ar2_done", 32'(done0), 1);
        chk("ar2_adder", 32'(a0), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_emitter.md
Name: pulse_emitter

Overview:
Transmit-side companion to the Adder counter: it accepts a count through a valid/ready load handshake and emits exactly that many single-cycle inc pulses, suitable for driving an Adder's inc input.
It sits between a control/sequencer block and one or more Adder instances.
Optional idle spacing between pulses, abort via clr, and a one-cycle done indication.
Summed over bursts, the Adder's out must equal the sum of the load values accepted by pulse_emitter, modulo 2^WIDTH.

Parameters:
WIDTH, 8, width of load_value and remaining; matches Adder WIDTH.
GAP, 0, idle cycles inserted between consecutive inc pulses; 0 means back-to-back pulses.

Ports:
aclk  input  1  clock; all logic on rising edge.
arstn  input  1  asynchronous active-low reset.
clr  input  1  synchronous abort of current burst; highest priority after arstn.
load_valid  input  1  load request qualifier.
load_ready  output  1  high when the block can accept a load (IDLE only).
load_value  input  WIDTH  number of pulses to emit; captured on handshake.
inc  output  1  registered pulse output, one cycle high per count.
remaining  output  WIDTH  pulses still to emit; registered.
busy  output  1  high in PULSE or GAP state.
done  output  1  one-cycle pulse when a burst completes normally.

Behaviour:
- Reset (arstn low, async): state IDLE; inc=0, remaining=0, busy=0, done=0, load_ready=1; gap counter=0.
- States: IDLE, PULSE, GAP, DONE. Encoding comes from the package.
- IDLE: load_ready=1. Handshake = load_valid & load_ready, sampled at edge k.
  - load_value==0: no pulses; done=1 in cycle k+1; stay IDLE.
  - Otherwise: remaining<=load_value, go to PULSE; first inc high in cycle k+1.
- PULSE: inc=1 for exactly this cycle. At the end of the cycle, remaining decrements by 1.
  - If remaining was 1: next state DONE.
  - Else if GAP>0: next state GAP, gap counter loaded with GAP-1.
  - Else: stay PULSE, so inc stays high on consecutive cycles.
- GAP: inc=0. Gap counter decrements each cycle; when it reaches 0, go to PULSE. Pulse period is GAP+1 cycles.
- DONE: done=1, busy=0, load_ready=0, remaining=0 for one cycle; then IDLE.
- Latency: handshake at edge k, GAP=0, value N gives inc high in cycles k+1..k+N and done in cycle k+N+1.
  - General case: done in cycle k+N+(N-1)*GAP+1.
- inc, busy and done are registered outputs, so they are glitch-free.
- load_ready is low in PULSE, GAP and DONE. A load_valid in those states is ignored and not queued.
- clr=1 at any edge:
  - next cycle state IDLE, remaining=0, inc=0, gap counter=0.
  - no done pulse.
  - any simultaneous load handshake is discarded.
- arstn asserted mid-burst: outputs go to reset values immediately (async). Pulses already issued are not replayed.
- remaining is unsigned WIDTH bits and never wraps. The maximum load is 2^WIDTH-1.
- GAP counter width is max(1, $clog2(GAP+1)).

Decomposition:
- Package pulse_emitter_pkg holds:
  - state typedef enum {IDLE, PULSE, GAP, DONE} as 2 bits;
  - localparam for the gap counter width function.
- Sub-module: none required. The gap timer is a few lines in the main FSM.
- Bench instantiates pulse_emitter driving an Adder (inc to inc, shared aclk/arstn/clr) as scoreboard.

Test Plan:
- GAP=0, load 5 after reset → inc high 5 consecutive cycles; remaining 5,4,3,2,1,0; done 1 cycle after last inc; Adder out=5.
- GAP=2, load 3 → inc high at k+1, k+4, k+7; done at k+8; Adder out=3; load_ready low k+1..k+8.
- load 0 → no inc; done=1 at k+1; load_ready stays 1; Adder out=0.
- load 255 (WIDTH=8), then load_valid=1 with value 7 held during the burst → exactly 255 pulses and the 7 is ignored while busy; 7 accepted after return to IDLE; Adder out wraps to (255+7) mod 256 = 6.
- clr asserted after 3rd pulse of a load-10 burst → inc=0 next cycle, remaining=0, no done, load_ready=1; Adder cleared to 0.
- arstn low mid-burst (async, between edges) → all outputs reset immediately; after release, load 2 → exactly 2 pulses and done.
